// File: rtl/vector_unit.sv
// vector_unit: SIMD vector unit executing one command at a time on a wide register file with SRAM load/store
module vector_unit #(
  parameter int LANES       = 64,
  parameter int DATA_WIDTH  = 16,
  parameter int VREG_COUNT  = 32,
  parameter int SRAM_ADDR_W = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [127:0]                  cmd,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  output logic                          cmd_done,
  output logic [SRAM_ADDR_W-1:0]        sram_addr,
  output logic [LANES*DATA_WIDTH-1:0]   sram_wdata,
  input  logic [LANES*DATA_WIDTH-1:0]   sram_rdata,
  output logic                          sram_we,
  output logic                          sram_re,
  input  logic                          sram_ready
);
  localparam int VW = LANES * DATA_WIDTH;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_SUB   = 8'h02;
  localparam logic [7:0] OP_MUL   = 8'h03;
  localparam logic [7:0] OP_MAX   = 8'h04;
  localparam logic [7:0] OP_MIN   = 8'h05;
  localparam logic [7:0] OP_RELU  = 8'h10;
  localparam logic [7:0] OP_LOAD  = 8'h30;
  localparam logic [7:0] OP_STORE = 8'h31;

  typedef enum logic [2:0] {IDLE, EXEC, RD_REQ, RD_W1, RD_W2, WR_REQ, DONE} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             subop_q, subop_d;
  logic [4:0]             vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [VW-1:0]          vreg_q [VREG_COUNT];
  logic [VW-1:0]          vreg_d [VREG_COUNT];
  logic [VW-1:0]          alu_res;
  logic [7:0]             cmd_op;
  logic [19:0]            cmd_addr;
  logic                   unused_cmd;

  assign cmd_op     = cmd[119:112];
  assign cmd_addr   = cmd[95:76];
  assign unused_cmd = ^{cmd[127:120], cmd[96], cmd[75:0]};

  // Per-lane signed ALU; the multiply keeps only the low DATA_WIDTH bits of the product
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] a, b, m;
    assign a = vreg_q[vs1_q][k*DATA_WIDTH +: DATA_WIDTH];
    assign b = vreg_q[vs2_q][k*DATA_WIDTH +: DATA_WIDTH];
    assign m = a * b;
    assign alu_res[k*DATA_WIDTH +: DATA_WIDTH] =
      subop_q == OP_ADD ? a + b :
      subop_q == OP_SUB ? a - b :
      subop_q == OP_MUL ? m :
      subop_q == OP_MAX ? (a > b ? a : b) :
      subop_q == OP_MIN ? (a < b ? a : b) :
      (a[DATA_WIDTH-1] ? '0 : a);
  end

  // SRAM strobes and bus values exist only in the request states; everything else idles at zero
  assign sram_re    = state_q == RD_REQ;
  assign sram_we    = state_q == WR_REQ;
  assign sram_addr  = (sram_re || sram_we) ? addr_q : '0;
  assign sram_wdata = sram_we ? vreg_q[vs1_q] : '0;
  assign cmd_ready  = state_q == IDLE || state_q == DONE;
  assign cmd_done   = state_q == DONE;

  // Command latch and next-state sequencing
  always_comb begin
    state_d = state_q;
    subop_d = subop_q;
    vd_d    = vd_q;
    vs1_d   = vs1_q;
    vs2_d   = vs2_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        subop_d = cmd_op;
        vd_d    = cmd[111:107];
        vs1_d   = cmd[106:102];
        vs2_d   = cmd[101:97];
        addr_d  = SRAM_ADDR_W'(cmd_addr);
        state_d = cmd_op inside {OP_ADD, OP_SUB, OP_MUL, OP_MAX, OP_MIN, OP_RELU} ? EXEC :
                  cmd_op == OP_LOAD ? RD_REQ : cmd_op == OP_STORE ? WR_REQ : DONE;
      end
      EXEC:    state_d = DONE;
      RD_REQ:  state_d = sram_ready ? RD_W1 : RD_REQ;
      RD_W1:   state_d = RD_W2;
      RD_W2:   state_d = DONE;
      WR_REQ:  state_d = sram_ready ? DONE : WR_REQ;
      DONE:    state_d = cmd_valid ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register file write: ALU result leaving EXEC, SRAM read data leaving RD_W2
  always_comb begin
    vreg_d = vreg_q;
    if (state_q == EXEC) vreg_d[vd_q] = alu_res;
    else if (state_q == RD_W2) vreg_d[vd_q] = sram_rdata;
  end

  // State, latched command fields and register file
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      subop_q <= '0;
      vd_q    <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      addr_q  <= '0;
      vreg_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      subop_q <= subop_d;
      vd_q    <= vd_d;
      vs1_q   <= vs1_d;
      vs2_q   <= vs2_d;
      addr_q  <= addr_d;
      vreg_q  <= vreg_d;
    end
  end
endmodule

// File: tb/tb_vector_unit.sv
// tb_vector_unit: directed plus random command checking of vector_unit against a lane-arithmetic model
module tb_vector_unit;
  localparam int L  = 64;
  localparam int DW = 16;
  localparam int VW = L * DW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [127:0]   cmd;
  logic           cmd_valid, cmd_ready, cmd_done;
  logic [19:0]    sram_addr;
  logic [VW-1:0]  sram_wdata, sram_rdata;
  logic           sram_we, sram_re, sram_ready;

  logic [VW-1:0]  mem [256];
  logic [VW-1:0]  ref_mem [256];
  logic [VW-1:0]  ref_v [32];
  logic [VW-1:0]  stage1;
  int             checks = 0;
  int             errors = 0;

  always #5 clk = ~clk;

  vector_unit dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_done(cmd_done), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_we(sram_we),
    .sram_re(sram_re), .sram_ready(sram_ready)
  );

  // SRAM with a two-register read pipeline
  always @(posedge clk) begin
    if (sram_re && sram_ready) stage1 <= mem[sram_addr[7:0]];
    sram_rdata <= stage1;
    if (sram_we && sram_ready) mem[sram_addr[7:0]] = sram_wdata;
  end

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic bit is_alu(input logic [7:0] op);
    return op inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10};
  endfunction

  function automatic logic [VW-1:0] ref_alu(input logic [7:0] op, input logic [VW-1:0] x, input logic [VW-1:0] y);
    logic [VW-1:0] r;
    for (int k = 0; k < L; k++) begin
      int a, b, o;
      a = $signed(x[k*DW +: DW]);
      b = $signed(y[k*DW +: DW]);
      case (op)
        8'h01:   o = a + b;
        8'h02:   o = a - b;
        8'h03:   o = a * b;
        8'h04:   o = a > b ? a : b;
        8'h05:   o = a < b ? a : b;
        default: o = a < 0 ? 0 : a;
      endcase
      r[k*DW +: DW] = o[15:0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    int lane;
    lane = 0;
    for (int k = L - 1; k >= 0; k--) if (obs[k*DW +: DW] !== exp[k*DW +: DW]) lane = k;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s lane %0d observed %h expected %h", tag, lane, obs[lane*DW +: DW], exp[lane*DW +: DW]);
    end
  endtask

  task automatic ref_exec(input logic [7:0] op, input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2, input logic [7:0] a);
    if (is_alu(op)) ref_v[vd] = ref_alu(op, ref_v[vs1], ref_v[vs2]);
    else if (op == 8'h30) ref_v[vd] = ref_mem[a];
    else if (op == 8'h31) ref_mem[a] = ref_v[vs1];
  endtask

  // Issue one command, watch the bus until done, hold valid, release, and check everything observed
  task automatic run(input logic [7:0] op, input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                     input logic [7:0] a, input int stall, input int hold);
    int cyc, re_c, we_c, lat;
    bit done, bad_bus, both, bad_hold;
    cyc = 0; re_c = 0; we_c = 0; done = 0; bad_bus = 0; both = 0; bad_hold = 0;
    lat = is_alu(op) ? 2 : op == 8'h30 ? 4 + stall : op == 8'h31 ? 2 + stall : 1;
    @(negedge clk);
    cmd = {4{$urandom()}};
    cmd[119:112] = op;
    cmd[111:107] = vd;
    cmd[106:102] = vs1;
    cmd[101:97]  = vs2;
    cmd[95:76]   = {12'h0, a};
    cmd_valid  = 1'b1;
    sram_ready = stall == 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (sram_re && sram_we) both = 1;
      if (sram_re) begin
        re_c++;
        if (sram_addr !== {12'h0, a}) bad_bus = 1;
      end
      if (sram_we) begin
        we_c++;
        if (sram_addr !== {12'h0, a} || sram_wdata !== ref_v[vs1]) bad_bus = 1;
      end
      if (!sram_re && !sram_we && (sram_addr !== '0 || sram_wdata !== '0)) bad_bus = 1;
      if (!cmd_done && cmd_ready !== 1'b0) bad_bus = 1;
      sram_ready = cyc >= stall + 1;
      if (cmd_done === 1'b1) done = 1;
    end
    chk("done_seen", 32'(done), 32'd1);
    if (!done) begin
      cmd_valid = 1'b0;
      return;
    end
    sram_ready = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (cmd_done !== 1'b1 || cmd_ready !== 1'b1) bad_hold = 1;
      if (sram_re) re_c++;
      if (sram_we) we_c++;
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("latency", 32'(cyc), 32'(lat));
    chk("re_cycles", 32'(re_c), op == 8'h30 ? 32'(1 + stall) : 32'd0);
    chk("we_cycles", 32'(we_c), op == 8'h31 ? 32'(1 + stall) : 32'd0);
    chk("bus_idle_addr_data", 32'(bad_bus), 32'd0);
    chk("re_we_exclusive", 32'(both), 32'd0);
    chk("done_held", 32'(bad_hold), 32'd0);
    chk("release_done", 32'(cmd_done), 32'd0);
    chk("release_ready", 32'(cmd_ready), 32'd1);
    ref_exec(op, vd, vs1, vs2, a);
    if (op == 8'h31) chkv("store_word", mem[a], ref_mem[a]);
  endtask

  initial begin
    logic [VW-1:0] e;
    logic [7:0] ops [9];
    bit bad;
    ops = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'h30, 8'h31, 8'h7F};
    rst_n = 1'b0; cmd = '0; cmd_valid = 1'b0; sram_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem[i] = rnd_vec();
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 32; i++) ref_v[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(cmd_done), 32'd0);
    chk("rst_strobes", 32'({sram_re, sram_we}), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chkv("rst_wdata", sram_wdata, '0);
    rst_n = 1'b1;

    for (int k = 0; k < L; k++) begin
      mem[0][k*DW +: DW] = 16'(k - 32);
      mem[1][k*DW +: DW] = 16'(-(k + 1));
      mem[2][k*DW +: DW] = 16'(k + 1);
      mem[3][k*DW +: DW] = 16'h7FFF;
      mem[4][k*DW +: DW] = 16'h0001;
    end
    for (int i = 0; i < 5; i++) ref_mem[i] = mem[i];

    run(8'h30, 5'd0, 5'd0, 5'd0, 8'h00, 0, 0);
    run(8'h10, 5'd1, 5'd0, 5'd0, 8'h00, 0, 0);
    run(8'h31, 5'd0, 5'd1, 5'd0, 8'h10, 0, 0);
    for (int k = 0; k < L; k++) e[k*DW +: DW] = k > 32 ? 16'(k - 32) : 16'h0;
    chkv("relu_mixed", mem[8'h10], e);

    run(8'h30, 5'd2, 5'd0, 5'd0, 8'h01, 0, 0);
    run(8'h10, 5'd3, 5'd2, 5'd0, 8'h00, 0, 0);
    run(8'h31, 5'd0, 5'd3, 5'd0, 8'h20, 0, 0);
    chkv("relu_all_neg", mem[8'h20], '0);

    run(8'h30, 5'd4, 5'd0, 5'd0, 8'h02, 0, 0);
    run(8'h10, 5'd5, 5'd4, 5'd0, 8'h00, 0, 0);
    run(8'h31, 5'd0, 5'd5, 5'd0, 8'h30, 0, 0);
    for (int k = 0; k < L; k++) e[k*DW +: DW] = 16'(k + 1);
    chkv("relu_all_pos", mem[8'h30], e);

    run(8'h30, 5'd6, 5'd0, 5'd0, 8'h03, 0, 0);
    run(8'h30, 5'd7, 5'd0, 5'd0, 8'h04, 0, 0);
    run(8'h01, 5'd8, 5'd6, 5'd7, 8'h00, 0, 0);
    run(8'h04, 5'd9, 5'd6, 5'd7, 8'h00, 0, 0);
    run(8'h31, 5'd0, 5'd8, 5'd0, 8'h40, 0, 0);
    run(8'h31, 5'd0, 5'd9, 5'd0, 8'h41, 0, 0);
    for (int k = 0; k < L; k++) e[k*DW +: DW] = 16'h8000;
    chkv("add_wrap", mem[8'h40], e);
    for (int k = 0; k < L; k++) e[k*DW +: DW] = 16'h7FFF;
    chkv("max_sat", mem[8'h41], e);

    run(8'h31, 5'd0, 5'd1, 5'd0, 8'h11, 0, 5);
    run(8'h7F, 5'd1, 5'd2, 5'd3, 8'h00, 0, 0);
    run(8'h30, 5'd10, 5'd0, 5'd0, 8'h02, 3, 0);
    run(8'h31, 5'd0, 5'd10, 5'd0, 8'h12, 0, 0);

    for (int i = 0; i < 60; i++)
      run(ops[$urandom_range(0, 8)], 5'($urandom()), 5'($urandom()), 5'($urandom()),
          8'($urandom()), $urandom_range(0, 2), $urandom_range(0, 2));

    @(negedge clk);
    cmd = '0;
    cmd[119:112] = 8'h30;
    cmd[111:107] = 5'd11;
    cmd[95:76]   = 20'h5;
    cmd_valid  = 1'b1;
    sram_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall_re_held", 32'(sram_re), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_strobes", 32'({sram_re, sram_we}), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_done", 32'(cmd_done), 32'd0);
    chk("midrst_addr", 32'(sram_addr), 32'd0);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    sram_ready = 1'b1;
    for (int i = 0; i < 32; i++) ref_v[i] = '0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (sram_re || sram_we) bad = 1;
    end
    chk("postrst_quiet", 32'(bad), 32'd0);
    run(8'h31, 5'd0, 5'd10, 5'd0, 8'h50, 0, 0);
    chkv("postrst_vreg_clear", mem[8'h50], '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
